// File: rtl/pll_ctrl.sv
// PLL sequencer: owns the PLL reset and divider inputs, applies new divider
// configurations through a valid/ready handshake, waits for lock with a
// timeout and bounded retries, detects loss of lock and gates clk_en_o.
//
// Ports:
//   clk_i, srst_i             controller clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o   divider configuration handshake
//   cfg_ref_div_i/fb_div_i    requested dividers
//   clear_i                   clear lol_o; restart from FAIL
//   pll_arst_no               PLL async reset, active-low
//   pll_ref_div_o/fb_div_o    registered dividers driven to the PLL
//   pll_locked_i              PLL lock, asynchronous to clk_i
//   clk_en_o, locked_o, fail_o, lol_o, busy_o, retry_cnt_o, state_o  status
module pll_ctrl #(
  parameter int unsigned REF_DIV_WIDTH   = 4,
  parameter int unsigned FB_DIV_WIDTH    = 8,
  parameter int unsigned DEFAULT_REF_DIV = 1,
  parameter int unsigned DEFAULT_FB_DIV  = 1,
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                               clk_i,
  input  logic                               srst_i,
  input  logic                               cfg_valid_i,
  output logic                               cfg_ready_o,
  input  logic [REF_DIV_WIDTH-1:0]           cfg_ref_div_i,
  input  logic [FB_DIV_WIDTH-1:0]            cfg_fb_div_i,
  input  logic                               clear_i,
  output logic                               pll_arst_no,
  output logic [REF_DIV_WIDTH-1:0]           pll_ref_div_o,
  output logic [FB_DIV_WIDTH-1:0]            pll_fb_div_o,
  input  logic                               pll_locked_i,
  output logic                               clk_en_o,
  output logic                               locked_o,
  output logic                               fail_o,
  output logic                               lol_o,
  output logic                               busy_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
  output logic [2:0]                         state_o
);

  localparam int unsigned RstW   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned TmoW   = $clog2(LOCK_TIMEOUT);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

  localparam logic [RstW-1:0]          RstLast    = RstW'(RESET_CYCLES - 1);
  localparam logic [TmoW-1:0]          TmoLast    = TmoW'(LOCK_TIMEOUT - 1);
  localparam logic [RetryW-1:0]        RetryMax   = RetryW'(MAX_RETRIES);
  localparam logic [REF_DIV_WIDTH-1:0] RefDefault = REF_DIV_WIDTH'(DEFAULT_REF_DIV);
  localparam logic [FB_DIV_WIDTH-1:0]  FbDefault  = FB_DIV_WIDTH'(DEFAULT_FB_DIV);

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StLocked   = 2'd2,
    StFail     = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [RstW-1:0]           rst_cnt_q, rst_cnt_d;
  logic [TmoW-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic [RetryW-1:0]         retry_q, retry_d;
  logic                      lol_q, lol_d;
  logic [REF_DIV_WIDTH-1:0]  ref_div_q, ref_div_d;
  logic [FB_DIV_WIDTH-1:0]   fb_div_q, fb_div_d;
  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      lk_s;
  logic                      cfg_hs;
  logic                      lol_set;
  logic                      cfg_latch;

  assign lk_s   = sync_q[SYNC_STAGES-1];
  // cfg_ready_o is decoded from state only, so this has no comb path to ready.
  assign cfg_hs = cfg_valid_i & cfg_ready_o;

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= StPllRst;
      rst_cnt_q <= '0;
      tmo_cnt_q <= '0;
      retry_q   <= '0;
      lol_q     <= 1'b0;
      ref_div_q <= RefDefault;
      fb_div_q  <= FbDefault;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      retry_q   <= retry_d;
      lol_q     <= lol_d;
      ref_div_q <= ref_div_d;
      fb_div_q  <= fb_div_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  // Next-state logic. Counters default to zero so they are clear on entry.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    tmo_cnt_d = '0;
    retry_d   = retry_q;
    lol_set   = 1'b0;
    cfg_latch = 1'b0;
    unique case (state_q)
      StPllRst: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StWaitLock;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (lk_s) begin
          state_d = StLocked;
        end else if (tmo_cnt_q == TmoLast) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 1'b1;
            state_d = StPllRst;
          end else begin
            state_d = StFail;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StLocked: begin
        if (cfg_hs) begin
          cfg_latch = 1'b1;
          retry_d   = '0;
          state_d   = StPllRst;
        end else if (!lk_s) begin
          // Loss of lock: wait for relock without resetting the PLL.
          lol_set = 1'b1;
          retry_d = '0;
          state_d = StWaitLock;
        end
      end
      StFail: begin
        if (cfg_hs) begin
          cfg_latch = 1'b1;
          retry_d   = '0;
          state_d   = StPllRst;
        end else if (clear_i) begin
          retry_d = '0;
          state_d = StPllRst;
        end
      end
      default: state_d = StPllRst;
    endcase

    ref_div_d = cfg_latch ? cfg_ref_div_i : ref_div_q;
    fb_div_d  = cfg_latch ? cfg_fb_div_i : fb_div_q;

    if (lol_set) begin
      lol_d = 1'b1;
    end else if (clear_i) begin
      lol_d = 1'b0;
    end else begin
      lol_d = lol_q;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    pll_arst_no = (state_q == StWaitLock) || (state_q == StLocked);
    clk_en_o    = (state_q == StLocked);
    locked_o    = (state_q == StLocked);
    fail_o      = (state_q == StFail);
    cfg_ready_o = (state_q == StLocked) || (state_q == StFail);
    busy_o      = (state_q == StPllRst) || (state_q == StWaitLock);
    state_o     = {1'b0, state_q};
  end

  assign pll_ref_div_o = ref_div_q;
  assign pll_fb_div_o  = fb_div_q;
  assign lol_o         = lol_q;
  assign retry_cnt_o   = retry_q;

endmodule

// File: doc/pll_ctrl.md
Name: pll_ctrl

Overview:
- Sequencer for the on-chip PLL. It owns the PLL's reset and divider inputs and applies reference and feedback divider configurations through a valid/ready handshake.
- It holds the PLL in reset, then waits for lock with a timeout and retries on failure. It detects loss of lock.
- It gates downstream clock use through clk_en_o.
- It runs on a free-running system clock asynchronous to the PLL lock output.

Parameters:
REF_DIV_WIDTH, 4, width of reference divider
FB_DIV_WIDTH, 8, width of feedback divider
DEFAULT_REF_DIV, 1, reference divider applied after reset
DEFAULT_FB_DIV, 1, feedback divider applied after reset
RESET_CYCLES, 16, cycles pll_arst_no held low per apply (>=1)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before timeout (>=2)
MAX_RETRIES, 3, reset/relock retries before FAIL
SYNC_STAGES, 2, synchronizer depth for pll_locked_i (>=2)

Ports:
clk_i  in  1  controller clock
srst_i  in  1  synchronous active-high reset
cfg_valid_i  in  1  new divider configuration valid
cfg_ready_o  out  1  configuration accepted when valid&ready
cfg_ref_div_i  in  REF_DIV_WIDTH  requested reference divider
cfg_fb_div_i  in  FB_DIV_WIDTH  requested feedback divider
clear_i  in  1  clear lol_o; in FAIL, restart with current divisors
pll_arst_no  out  1  PLL async reset, active-low
pll_ref_div_o  out  REF_DIV_WIDTH  divider driven to PLL
pll_fb_div_o  out  FB_DIV_WIDTH  divider driven to PLL
pll_locked_i  in  1  PLL lock, asynchronous to clk_i
clk_en_o  out  1  PLL output safe to use
locked_o  out  1  controller in LOCKED
fail_o  out  1  controller in FAIL
lol_o  out  1  sticky loss-of-lock flag
busy_o  out  1  PLL_RST or WAIT_LOCK
retry_cnt_o  out  $clog2(MAX_RETRIES+1)  retries used in current attempt
state_o  out  3  0 PLL_RST, 1 WAIT_LOCK, 2 LOCKED, 3 FAIL

Behaviour:

Interface:
- One clock, clk_i. Reset srst_i is synchronous and active-high.

Reset (srst_i=1):
- State is PLL_RST with the reset counter cleared.
- pll_arst_no=0.
- pll_ref_div_o=DEFAULT_REF_DIV and pll_fb_div_o=DEFAULT_FB_DIV.
- cfg_ready_o=0, clk_en_o=0, locked_o=0, fail_o=0, lol_o=0, busy_o=1, retry_cnt_o=0.
- Synchronizer flops are cleared.

Lock input:
- pll_locked_i passes through SYNC_STAGES flops to give lk_s.
- Only lk_s is used.

Divider outputs:
- Registered. They change only on cfg acceptance and are stable otherwise.
- Zero values pass through unmodified.

PLL_RST:
- pll_arst_no=0.
- The counter runs 0..RESET_CYCLES-1, then the state goes to WAIT_LOCK.
- pll_arst_no=1 from the first WAIT_LOCK cycle.

WAIT_LOCK:
- The timeout counter clears on entry and increments each cycle.
- lk_s=1 goes to LOCKED.
- If the counter reaches LOCK_TIMEOUT-1 with lk_s=0:
  - if retry_cnt < MAX_RETRIES, increment retry_cnt and go to PLL_RST;
  - otherwise go to FAIL.
- Lock and timeout in the same cycle: lock wins.

LOCKED:
- clk_en_o=1, locked_o=1, cfg_ready_o=1.
- cfg_valid_i handshake:
  - latch divisors, clear retry_cnt, go to PLL_RST;
  - the new divisors and pll_arst_no=0 appear on the next cycle;
  - clk_en_o drops that same cycle.
- lk_s=0 without a handshake:
  - set lol_o, clear retry_cnt, go to WAIT_LOCK with no PLL reset;
  - clk_en_o drops next cycle.
- Handshake and lk_s fall in the same cycle: the handshake wins and lol_o is not set.

FAIL:
- fail_o=1, cfg_ready_o=1, pll_arst_no=0.
- A cfg handshake latches the divisors, clears retry_cnt and goes to PLL_RST.
- clear_i alone clears retry_cnt and goes to PLL_RST with the current divisors.
- Handshake and clear_i together: the handshake wins (new divisors).

Handshake:
- cfg_ready_o=0 in PLL_RST and WAIT_LOCK.
- Requests are never dropped.
- The requester holds valid and data until ready.

lol_o:
- Cleared by clear_i in any state.
- Set and clear in the same cycle: set wins.

Outputs:
- All outputs are registered or decoded from registered state.
- No combinational path from cfg_valid_i to cfg_ready_o.

Test Plan:
Parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=64, MAX_RETRIES=2, SYNC_STAGES=2.
1. Release srst_i; raise pll_locked_i 10 cycles after pll_arst_no rises.
   -> pll_arst_no low for exactly 4 cycles; divisors 1/1; LOCKED 2–3 cycles after lock rises; clk_en_o=1, cfg_ready_o=1.
2. In LOCKED, handshake ref=3 and fb=40.
   -> next cycle: divisors 3/40, pll_arst_no=0, clk_en_o=0, cfg_ready_o=0; relock sequence repeats.
3. Hold pll_locked_i=0 throughout.
   -> three PLL_RST/WAIT_LOCK cycles with retry_cnt_o 0, 1, 2, each WAIT_LOCK 64 cycles; then FAIL with fail_o=1.
   -> clear_i then restarts with retry_cnt_o=0.
4. In LOCKED, pulse pll_locked_i low for 5 cycles.
   -> lol_o=1, state WAIT_LOCK, pll_arst_no stays 1; returns to LOCKED on relock; lol_o stays 1 until clear_i.
5. Lock rising on the final timeout cycle -> LOCKED with retry_cnt_o unchanged.
   - cfg handshake coinciding with lk_s fall -> PLL_RST, lol_o=0.
6. Assert srst_i mid-WAIT_LOCK (retry_cnt_o=1, divisors 3/40).
   -> next cycle: all reset values, divisors 1/1.
